// File: rtl/fpga_robots_game_uart_rx_pkg.sv
// Shared constants and state encoding for the robots-game UART receiver.
package fpga_robots_game_uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 8;
   localparam int unsigned MID_TICK   = 4;

   localparam logic [2:0] TICK_LAST = 3'(OVERSAMPLE - 1);
   localparam logic [2:0] TICK_MID  = 3'(MID_TICK - 1);

endpackage

// File: rtl/fpga_robots_game_rxfifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same clock.
module fpga_robots_game_rxfifo #(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   logic [7:0]       mem_q [DEPTH];
   logic [FIFO_AW:0] wptr_q, wptr_d;
   logic [FIFO_AW:0] rptr_q, rptr_d;
   logic             do_push, do_pop;

   // Extra MSB on each pointer separates full (MSBs differ) from empty.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rptr_q[FIFO_AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (do_push) mem_q[wptr_q[FIFO_AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/fpga_robots_game_uart_rx.sv
// 8N1 UART receiver oversampling at 8x baud, feeding a small FWFT FIFO with
// sticky framing-error and overrun flags.
module fpga_robots_game_uart_rx
   import fpga_robots_game_uart_rx_pkg::*;
#(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud8,
   input  logic       serial_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_err,
   output logic       overrun,
   input  logic       clr_err
);

   rx_state_e  state_q, state_d;
   logic [2:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       sync1_q, sync2_q;
   logic       ferr_q, ferr_d;
   logic       ovr_q, ovr_d;
   logic       line;
   logic       push, ferr_set, pop, fifo_empty, fifo_full;

   assign line = sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= serial_rx;
         sync2_q <= sync1_q;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (baud8) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!line) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            ST_START: begin
               if (tick_q == TICK_MID) begin
                  if (!line) begin
                     state_d = ST_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 3'd1;
               end
            end
            ST_DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = {line, shift_q[7:1]};
                  if (bit_q == 3'd7) state_d = ST_STOP;
                  else               bit_d   = bit_q + 3'd1;
               end else begin
                  tick_d = tick_q + 3'd1;
               end
            end
            ST_STOP: begin
               if (tick_q == TICK_LAST) begin
                  if (line) begin
                     push    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = ST_WAIT_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 3'd1;
               end
            end
            ST_WAIT_IDLE: begin
               if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pop = rx_valid && rx_ready;

   // Error set is evaluated after clear so a coincident event wins.
   always_comb begin
      ferr_d = ferr_q;
      ovr_d  = ovr_q;
      if (clr_err) begin
         ferr_d = 1'b0;
         ovr_d  = 1'b0;
      end
      if (ferr_set)                  ferr_d = 1'b1;
      if (push && fifo_full && !pop) ovr_d  = 1'b1;
   end

   fpga_robots_game_rxfifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (shift_q),
      .pop   (pop),
      .dout  (rx_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign rx_valid    = !fifo_empty;
   assign framing_err = ferr_q;
   assign overrun     = ovr_q;

endmodule
